// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared definitions for the program loader.
//   - state_t   : loader FSM state encoding (CSUM present only when
//                 PROG_LOADER_CHECKSUM_EN is defined)
//   - LEN_BYTES : number of little-endian bytes in the length field
//   - csum_add  : modulo-256 running payload checksum
package prog_loader_pkg;

  localparam int LEN_BYTES = 4;

  typedef enum logic [2:0] {
    ST_HOLD = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
`ifdef PROG_LOADER_CHECKSUM_EN
    ST_CSUM = 3'd3,
`endif
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input and instruction-memory write port.
//   rx_valid/rx_data/rx_ready : byte source handshake
//   im_we/im_waddr/im_wdata   : instruction-memory write strobe, address, data
// modport master : the loader (consumes bytes, drives memory writes)
// modport slave  : the byte source / memory side
interface prog_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [DATA_W-1:0] im_wdata;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, im_we, im_waddr, im_wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, im_we, im_waddr, im_wdata
  );
endinterface

// File: rtl/prog_loader_byte_packer.sv
// byte_packer: gathers bytes little-endian into DATA_W-bit words.
//   clk, resetb : clock, async active-low reset
//   clr         : synchronous clear of the partial word and byte count
//   byte_valid  : byte_in is consumed this cycle
//   byte_in     : incoming byte (first byte of a word lands in [7:0])
//   word_valid  : combinational, high when byte_in completes a word
//   word        : the completed word (valid with word_valid)
// DATA_W must be a multiple of 8 and at least 16.
module byte_packer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              clr,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic              word_valid,
  output logic [DATA_W-1:0] word
);

  localparam int BPW   = DATA_W / 8;
  localparam int CNT_W = $clog2(BPW) + 1;

  logic [DATA_W-9:0] acc_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              last_s;

  // The word is presented combinationally so the caller can register it on the same edge that takes the final byte.
  always_comb begin
    last_s     = (cnt_r == CNT_W'(BPW - 1));
    word       = {byte_in, acc_r};
    word_valid = byte_valid && last_s;
  end

  // Shift bytes in from the top so the oldest byte ends up in the low lane.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      acc_r <= {(DATA_W-8){1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      acc_r <= {(DATA_W-8){1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else if (byte_valid) begin
      acc_r <= word[DATA_W-1:8];
      cnt_r <= last_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: fills instruction memory from a byte stream and holds the core
// in reset until the image is complete.
//   clk, resetb  : clock, async active-low reset
//   start        : single-cycle load request (honoured in HOLD, RUN, ERR)
//   bus          : prog_loader_if.master (byte stream in, memory writes out)
//   core_resetb  : active-low reset to the core (high only while running)
//   busy         : a load is in progress
//   done / error : outcome of the last load
// Image format: 4-byte little-endian word count, then count*BPW payload bytes,
// plus one checksum byte when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          start,
  prog_loader_if.master bus,
  output logic          core_resetb,
  output logic          busy,
  output logic          done,
  output logic          error
);

  // One extra bit so a count equal to DEPTH_WORDS is representable.
  localparam int CNT_W = ADDR_W + 1;

  state_t            state_r;
  logic [1:0]        lcnt_r;
  logic [23:0]       len_sh_r;
  logic [CNT_W-1:0]  len_r;
  logic [CNT_W-1:0]  wcnt_r;
  logic              rx_ready_r;
  logic              im_we_r;
  logic [ADDR_W-1:0] im_waddr_r;
  logic [DATA_W-1:0] im_wdata_r;
  logic              core_resetb_r;
  logic              busy_r;
  logic              done_r;
  logic              error_r;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        sum_r;
`endif

  logic              accept_s;
  logic              pk_clr_s;
  logic              word_valid_s;
  logic [DATA_W-1:0] word_s;
  logic [31:0]       len_full_s;
  logic              len_bad_s;
  logic              last_word_s;

  // Handshake, length decode and end-of-payload detection.
  always_comb begin
    accept_s    = bus.rx_valid && rx_ready_r;
    pk_clr_s    = (state_r != ST_DATA);
    len_full_s  = {bus.rx_data, len_sh_r};
    len_bad_s   = (len_full_s == 32'd0) || (len_full_s > 32'(DEPTH_WORDS));
    last_word_s = (wcnt_r == len_r - CNT_W'(1));
  end

  // The packer stays cleared outside DATA, so every payload starts on a word boundary.
  byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk        (clk),
    .resetb     (resetb),
    .clr        (pk_clr_s),
    .byte_valid (accept_s),
    .byte_in    (bus.rx_data),
    .word_valid (word_valid_s),
    .word       (word_s)
  );

  // Loader FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_r       <= ST_HOLD;
      lcnt_r        <= 2'd0;
      len_sh_r      <= 24'd0;
      len_r         <= {CNT_W{1'b0}};
      wcnt_r        <= {CNT_W{1'b0}};
      rx_ready_r    <= 1'b0;
      im_we_r       <= 1'b0;
      im_waddr_r    <= {ADDR_W{1'b0}};
      im_wdata_r    <= {DATA_W{1'b0}};
      core_resetb_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      error_r       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_r         <= 8'd0;
`endif
    end else begin
      im_we_r       <= 1'b0;
      core_resetb_r <= 1'b0;
      case (state_r)
        ST_HOLD, ST_RUN, ST_ERR: begin
          // Release lags RUN entry by one edge so the last write completes first;
          // a start in RUN re-holds the core from the next cycle.
          core_resetb_r <= (state_r == ST_RUN) && !start;
          if (start) begin
            state_r    <= ST_LEN;
            lcnt_r     <= 2'd0;
            rx_ready_r <= 1'b1;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_r      <= 8'd0;
`endif
          end
        end
        ST_LEN: begin
          if (accept_s) begin
            lcnt_r   <= lcnt_r + 2'd1;
            len_sh_r <= len_full_s[31:8];
            if (lcnt_r == 2'(LEN_BYTES - 1)) begin
              if (len_bad_s) begin
                state_r    <= ST_ERR;
                rx_ready_r <= 1'b0;
                busy_r     <= 1'b0;
                error_r    <= 1'b1;
              end else begin
                state_r <= ST_DATA;
                len_r   <= len_full_s[CNT_W-1:0];
                wcnt_r  <= {CNT_W{1'b0}};
              end
            end
          end
        end
        ST_DATA: begin
          if (accept_s) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_r <= csum_add(sum_r, bus.rx_data);
`endif
            if (word_valid_s) begin
              im_we_r    <= 1'b1;
              im_waddr_r <= wcnt_r[ADDR_W-1:0];
              im_wdata_r <= word_s;
              wcnt_r     <= wcnt_r + CNT_W'(1);
              if (last_word_s) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                state_r    <= ST_CSUM;
`else
                state_r    <= ST_RUN;
                rx_ready_r <= 1'b0;
                busy_r     <= 1'b0;
                done_r     <= 1'b1;
`endif
              end
            end
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (accept_s) begin
            rx_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            if (bus.rx_data == sum_r) begin
              state_r <= ST_RUN;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_ERR;
              error_r <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_r    <= ST_HOLD;
          rx_ready_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_ready = rx_ready_r;
  assign bus.im_we    = im_we_r;
  assign bus.im_waddr = im_waddr_r;
  assign bus.im_wdata = im_wdata_r;
  assign core_resetb  = core_resetb_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign error        = error_r;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized self-checking bench for prog_loader.
// A transaction-level model predicts the memory writes and the load outcome
// for each image; a negedge monitor checks every write, the write latency,
// the release timing and the ready/busy relation on every cycle.
module tb_prog_loader;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int BPW    = DATA_W / 8;

  logic clk_tb = 1'b0;
  logic resetb;
  logic start;
  logic core_resetb, busy, done, error;

  prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) pif ();

  prog_loader #(.DEPTH_WORDS(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk_tb),
    .resetb      (resetb),
    .start       (start),
    .bus         (pif),
    .core_resetb (core_resetb),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk_tb = ~clk_tb;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_acc = -100;
  bit acc_prev = 1'b0;
  bit prev_crb = 1'b0;
  int last_we_addr = -1;

  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [DATA_W-1:0] exp_data_q[$];
  logic [DATA_W-1:0] exp_mem[DEPTH];
  logic [DATA_W-1:0] tb_mem[DEPTH];
  logic [7:0]        pay[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: checks every write against the model queue plus cycle-level timing.
  always @(negedge clk_tb) begin
    cyc++;
    if (resetb === 1'b1) begin
      chk("ready_eq_busy", pif.rx_ready, busy);
      if (pif.im_we) begin
        chk("we_latency", acc_prev, 1);
        if (exp_addr_q.size() == 0) begin
          chk("unexpected_we", 1, 0);
        end else begin
          chk("we_addr", pif.im_waddr, exp_addr_q.pop_front());
          chk("we_data", pif.im_wdata, exp_data_q.pop_front());
        end
        tb_mem[pif.im_waddr] = pif.im_wdata;
        last_we_addr = int'(pif.im_waddr);
      end
      if (core_resetb && !prev_crb) chk("release_cycle", cyc - last_acc, 2);
      if (pif.rx_valid && pif.rx_ready) last_acc = cyc;
    end
    acc_prev = (resetb === 1'b1) && pif.rx_valid && pif.rx_ready;
    prev_crb = (resetb === 1'b1) && core_resetb;
  end

  task automatic send_byte(input logic [7:0] b, input bit jitter);
    bit acc;
    bit got = 1'b0;
    if (jitter) begin
      repeat ($urandom_range(0, 2)) begin
        pif.rx_valid = 1'b0;
        pif.rx_data  = 8'($urandom);
        @(posedge clk_tb); #1;
      end
    end
    pif.rx_valid = 1'b1;
    pif.rx_data  = b;
    for (int t = 0; t < 20; t++) begin
      acc = pif.rx_ready;
      @(posedge clk_tb); #1;
      if (acc) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("byte_timeout", 0, 1);
      pif.rx_valid = 1'b0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk_tb); #1;
    start = 1'b0;
  endtask

  task automatic fill_pay(input int nbytes, input bit seq);
    pay.delete();
    for (int i = 0; i < nbytes; i++) pay.push_back(seq ? 8'(i) : 8'($urandom));
  endtask

  // Model one complete load: predict the writes and outcome, drive the image, then check.
  task automatic do_load(input logic [31:0] len, input bit jitter, input bit corrupt);
    bit ok;
    bit succ;
    logic [7:0] sum;
    logic [DATA_W-1:0] w;
    int n;
    ok   = (len != 32'd0) && (len <= 32'(DEPTH));
    succ = ok;
`ifdef PROG_LOADER_CHECKSUM_EN
    if (corrupt) succ = 1'b0;
`else
    if (corrupt) succ = ok;
`endif
    pulse_start();
    chk("start_busy", busy, 1);
    chk("start_ready", pif.rx_ready, 1);
    chk("start_done", done, 0);
    chk("start_error", error, 0);
    chk("start_core", core_resetb, 0);
    n   = ok ? int'(len) : 0;
    sum = 8'd0;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < BPW; b++) begin
        w[8*b +: 8] = pay[i*BPW + b];
        sum = sum + pay[i*BPW + b];
      end
      exp_addr_q.push_back(ADDR_W'(i));
      exp_data_q.push_back(w);
      exp_mem[i] = w;
    end
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], jitter);
    for (int i = 0; i < n * BPW; i++) send_byte(pay[i], jitter);
`ifdef PROG_LOADER_CHECKSUM_EN
    if (ok) send_byte(corrupt ? sum + 8'd1 : sum, jitter);
`endif
    pif.rx_valid = 1'b0;
    repeat (3) @(posedge clk_tb);
    #1;
    chk("end_done", done, succ);
    chk("end_error", error, !succ);
    chk("end_core", core_resetb, succ);
    chk("end_busy", busy, 0);
    chk("end_writes_left", exp_addr_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      exp_mem[i] = '0;
      tb_mem[i]  = '0;
    end
    resetb       = 1'b1;
    start        = 1'b0;
    pif.rx_valid = 1'b0;
    pif.rx_data  = 8'd0;
    #2 resetb = 1'b0;
    #20;
    chk("rst_ready", pif.rx_ready, 0);
    chk("rst_we", pif.im_we, 0);
    chk("rst_waddr", pif.im_waddr, 0);
    chk("rst_wdata", pif.im_wdata, 0);
    chk("rst_core", core_resetb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    @(posedge clk_tb); #1;
    resetb = 1'b1;
    @(posedge clk_tb); #1;

    // len=3, bytes 00..0B back to back
    fill_pay(3 * BPW, 1'b1);
    do_load(32'd3, 1'b0, 1'b0);
    chk("lit_w0", tb_mem[0], 32'h03020100);
    chk("lit_w1", tb_mem[1], 32'h07060504);
    chk("lit_w2", tb_mem[2], 32'h0B0A0908);

    // zero length: error, no writes, core held
    do_load(32'd0, 1'b0, 1'b0);
    repeat (4) @(posedge clk_tb);
    #1;
    chk("err_core_held", core_resetb, 0);

    // reload len=1 with EF BE AD DE
    pay = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_load(32'd1, 1'b0, 1'b0);
    chk("lit_dead", tb_mem[0], 32'hDEADBEEF);
    chk("lit_keep", tb_mem[1], 32'h07060504);

    // oversize length, then exactly full depth
    do_load(32'(DEPTH + 1), 1'b0, 1'b0);
    fill_pay(DEPTH * BPW, 1'b0);
    do_load(32'(DEPTH), 1'b0, 1'b0);
    chk("full_last_addr", last_we_addr, DEPTH - 1);

    // same 00..0B image with random gaps between bytes
    fill_pay(3 * BPW, 1'b1);
    do_load(32'd3, 1'b1, 1'b0);
    chk("jit_w2", tb_mem[2], 32'h0B0A0908);

`ifdef PROG_LOADER_CHECKSUM_EN
    pay = '{8'h01, 8'h02, 8'h03, 8'h04};
    do_load(32'd1, 1'b0, 1'b0);
    chk("csum_ok_word", tb_mem[0], 32'h04030201);
    do_load(32'd1, 1'b0, 1'b1);
`endif

    // randomized images
    for (int it = 0; it < 8; it++) begin
      logic [31:0] rl;
      if ($urandom_range(0, 5) == 0) rl = 32'(DEPTH + $urandom_range(1, 300));
      else rl = 32'($urandom_range(1, DEPTH));
      fill_pay(DEPTH * BPW, 1'b0);
      do_load(rl, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    // reset after 2 of 4 words
    fill_pay(4 * BPW, 1'b0);
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      logic [DATA_W-1:0] w;
      for (int b = 0; b < BPW; b++) w[8*b +: 8] = pay[i*BPW + b];
      exp_addr_q.push_back(ADDR_W'(i));
      exp_data_q.push_back(w);
      exp_mem[i] = w;
    end
    for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'd4 : 8'd0, 1'b0);
    for (int i = 0; i < 2 * BPW; i++) send_byte(pay[i], 1'b1);
    pif.rx_valid = 1'b0;
    @(negedge clk_tb); #1;
    resetb = 1'b0;
    repeat (2) @(posedge clk_tb);
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_core", core_resetb, 0);
    chk("mid_rst_ready", pif.rx_ready, 0);
    chk("mid_rst_done", done, 0);
    resetb = 1'b1;
    repeat (3) @(posedge clk_tb);
    #1;
    chk("mid_rst_hold_core", core_resetb, 0);
    chk("mid_rst_hold_busy", busy, 0);
    chk("mid_rst_writes_left", exp_addr_q.size(), 0);

    for (int a = 0; a < DEPTH; a++) chk($sformatf("mem_%0d", a), tb_mem[a], exp_mem[a]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
